// File: rtl/icache_refill_ctrl.sv
// Purpose : I-cache miss/refill controller; fetches one line from IRAM, writes data array then tag/valid.
// Latency : miss accepted at cycle 0, INSTALL at 1+N*WORDS_PER_LINE for N-cycle word spacing; stall drops next cycle.
// Backpress: none on the word stream (word_ready is a pulse, every word is consumed); fetch held by stall.
// Optional : ICACHE_EARLY_RESTART_EN adds early_valid/early_word and releases stall on the critical word.
module icache_refill_ctrl #(
  parameter int PC_W           = 32,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int INDEX_W        = 6,
  localparam int OFF_W         = $clog2(WORDS_PER_LINE),
  localparam int TAG_W         = PC_W - INDEX_W - OFF_W - 2
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                lookup_miss,
  input  logic [PC_W-1:0]     miss_pc,
  input  logic                flush,
  input  logic                word_ready,
  input  logic [WORD_W-1:0]   imem_word,
  output logic                i_miss,
  output logic [PC_W-1:0]     iram_address,
  output logic                fill_we,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [OFF_W-1:0]    fill_offset,
  output logic [WORD_W-1:0]   fill_data,
  output logic                tag_we,
  output logic [TAG_W-1:0]    fill_tag,
  output logic                stall,
  output logic                fill_done
`ifdef ICACHE_EARLY_RESTART_EN
  ,
  output logic                early_valid,
  output logic [WORD_W-1:0]   early_word
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    INSTALL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    cnt_q;
  logic [PC_W-1:0]     addr_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [TAG_W-1:0]    tag_q;
  logic                i_miss_q;
  logic                accept;
  logic                word_take;
  logic                last_word;
  logic                stall_base;

  // Address split of the missing byte PC.
  logic [PC_W-1:0]     pc_base;
  logic [INDEX_W-1:0]  pc_index;
  logic [TAG_W-1:0]    pc_tag;
  logic [OFF_W-1:0]    pc_offset;

  assign pc_base   = {2'b00, miss_pc[PC_W-1:OFF_W+2], {OFF_W{1'b0}}};
  assign pc_index  = miss_pc[INDEX_W+OFF_W+1:OFF_W+2];
  assign pc_tag    = miss_pc[PC_W-1:INDEX_W+OFF_W+2];
  assign pc_offset = miss_pc[OFF_W+1:2];

  // Byte-lane bits never matter; offset bits only matter with early restart.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{miss_pc[1:0], pc_offset};

  assign word_take = (state_q == REFILL) && word_ready;
  assign last_word = word_take && (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

  // Next-state and strobe decode; flush only gates acceptance, never aborts a refill.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    fill_we    = 1'b0;
    tag_we     = 1'b0;
    fill_done  = 1'b0;
    stall_base = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup_miss && !flush) begin
          accept  = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        stall_base = 1'b1;
        fill_we    = word_ready;
        if (last_word) begin
          state_d = INSTALL;
        end
      end
      INSTALL: begin
        stall_base = 1'b1;
        tag_we     = 1'b1;
        fill_done  = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; i_miss is a flop so it is high only for REFILL cycles and drops in INSTALL.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      i_miss_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_miss_q <= (state_d == REFILL);
    end
  end

  // Line context captured at miss acceptance; word counter walks the line in order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q <= '0;
      idx_q  <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      addr_q <= pc_base;
      idx_q  <= pc_index;
      tag_q  <= pc_tag;
      cnt_q  <= '0;
    end else if (word_take) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign i_miss       = i_miss_q;
  assign iram_address = addr_q;
  assign fill_index   = idx_q;
  assign fill_offset  = cnt_q;
  assign fill_data    = imem_word;
  assign fill_tag     = tag_q;

`ifdef ICACHE_EARLY_RESTART_EN
  logic [OFF_W-1:0] crit_q;
  logic             flush_seen_q;
  logic             released_q;

  // Forward the critical word once, unless a flush has made the waiting fetch stale.
  assign early_valid = word_take && (cnt_q == crit_q) && !flush_seen_q && !flush;
  assign early_word  = imem_word;

  // Track critical offset, flush history and whether fetch was already let go.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crit_q       <= '0;
      flush_seen_q <= 1'b0;
      released_q   <= 1'b0;
    end else if (accept) begin
      crit_q       <= pc_offset;
      flush_seen_q <= 1'b0;
      released_q   <= 1'b0;
    end else begin
      if ((state_q != IDLE) && flush) begin
        flush_seen_q <= 1'b1;
      end
      if (early_valid) begin
        released_q <= 1'b1;
      end
    end
  end

  assign stall = stall_base && !released_q;
`else
  assign stall = stall_base;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Purpose : self-checking bench for icache_refill_ctrl; vector table of refills plus reset/spurious sequences.
// Latency : checks INSTALL lands exactly 1+N*4 cycles after acceptance for each word spacing N.
// Backpress: fill writes and tag writes are scoreboarded through queues popped by a negedge monitor.
module tb_icache_refill_ctrl;

  logic        clk;
  logic        nrst;
  logic        lookup_miss;
  logic [31:0] miss_pc;
  logic        flush;
  logic        word_ready;
  logic [31:0] imem_word;
  logic        i_miss;
  logic [31:0] iram_address;
  logic        fill_we;
  logic [5:0]  fill_index;
  logic [1:0]  fill_offset;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [21:0] fill_tag;
  logic        stall;
  logic        fill_done;
`ifdef ICACHE_EARLY_RESTART_EN
  logic        early_valid;
  logic [31:0] early_word;
`endif

  icache_refill_ctrl dut (
    .clk          (clk),
    .nrst         (nrst),
    .lookup_miss  (lookup_miss),
    .miss_pc      (miss_pc),
    .flush        (flush),
    .word_ready   (word_ready),
    .imem_word    (imem_word),
    .i_miss       (i_miss),
    .iram_address (iram_address),
    .fill_we      (fill_we),
    .fill_index   (fill_index),
    .fill_offset  (fill_offset),
    .fill_data    (fill_data),
    .tag_we       (tag_we),
    .fill_tag     (fill_tag),
    .stall        (stall),
    .fill_done    (fill_done)
`ifdef ICACHE_EARLY_RESTART_EN
    ,
    .early_valid  (early_valid),
    .early_word   (early_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [1:0]  off;
    logic [31:0] dat;
  } fill_t;

  typedef struct {
    logic [31:0] pc;
    int          n;
    logic [31:0] addr;
    logic [5:0]  idx;
    logic [21:0] tag;
    int          flush_at;
    bit          spur;
    bit          hold;
    logic [31:0] base;
  } vec_t;

  fill_t       fq[$];
  logic [21:0] tq[$];
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every data-array and tag write must match a queued expectation.
  always @(negedge clk) begin
    if (nrst) begin
      if (fill_we) begin
        if (fq.size() == 0) begin
          chk("unexpected_fill_we", 64'(fill_we), 64'd0);
        end else begin
          fill_t e;
          e = fq.pop_front();
          chk("fill_index", 64'(fill_index), 64'(e.idx));
          chk("fill_offset", 64'(fill_offset), 64'(e.off));
          chk("fill_data", 64'(fill_data), 64'(e.dat));
        end
      end
      if (tag_we) begin
        if (tq.size() == 0) begin
          chk("unexpected_tag_we", 64'(tag_we), 64'd0);
        end else begin
          logic [21:0] t;
          t = tq.pop_front();
          chk("fill_tag", 64'(fill_tag), 64'(t));
        end
      end
    end
  end

  // One complete refill driven from IDLE; returns one cycle after INSTALL (back in IDLE).
  task automatic run_refill(input vec_t v, input bit hold, input logic [31:0] next_pc);
    bit    rel;
    bit    ev;
    fill_t e;
`ifdef ICACHE_EARLY_RESTART_EN
    bit       fseen;
    int       crit;
    fseen = 1'b0;
    crit  = int'(v.pc[3:2]);
`endif
    rel = 1'b0;
    lookup_miss = 1'b1;
    miss_pc     = v.pc;
    @(negedge clk);
    chk("idle_i_miss", 64'(i_miss), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    if (hold) miss_pc = next_pc;
    else lookup_miss = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int s = 1; s < v.n; s++) begin
        @(negedge clk);
        chk("gap_i_miss", 64'(i_miss), 64'd1);
        chk("gap_fill_we", 64'(fill_we), 64'd0);
        chk("gap_stall", 64'(stall), 64'(!rel));
        @(posedge clk); #1;
      end
      word_ready = 1'b1;
      imem_word  = v.base + 32'(k);
      flush      = (k == v.flush_at);
      e.idx = v.idx;
      e.off = 2'(k);
      e.dat = v.base + 32'(k);
      fq.push_back(e);
      if (k == 3) tq.push_back(v.tag);
      ev = 1'b0;
`ifdef ICACHE_EARLY_RESTART_EN
      ev    = (k == crit) && !fseen && !flush;
      fseen = fseen | flush;
`endif
      @(negedge clk);
      chk("word_i_miss", 64'(i_miss), 64'd1);
      chk("word_stall", 64'(stall), 64'(!rel));
      chk("word_tag_we", 64'(tag_we), 64'd0);
      if (k == 0) chk("iram_address", 64'(iram_address), 64'(v.addr));
`ifdef ICACHE_EARLY_RESTART_EN
      chk("early_valid", 64'(early_valid), 64'(ev));
      if (ev) chk("early_word", 64'(early_word), 64'(v.base + 32'(k)));
`endif
      @(posedge clk); #1;
      word_ready = 1'b0;
      flush      = 1'b0;
      rel        = rel | ev;
    end
    if (v.spur) begin
      word_ready = 1'b1;
      imem_word  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    chk("install_tag_we", 64'(tag_we), 64'd1);
    chk("install_fill_done", 64'(fill_done), 64'd1);
    chk("install_i_miss", 64'(i_miss), 64'd0);
    chk("install_stall", 64'(stall), 64'(!rel));
    chk("install_fill_we", 64'(fill_we), 64'd0);
    @(posedge clk); #1;
    word_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_t e;
    //           pc             n  addr           idx    tag        fl  sp hold base
    vecs[0] = '{32'h0000_0048, 2, 32'h0000_0010, 6'h04, 22'h00000, -1, 0, 0, 32'h0000_00A0};
    vecs[1] = '{32'h1234_5678, 1, 32'h048D_159C, 6'h27, 22'h48D15, -1, 0, 0, 32'h1111_0000};
    vecs[2] = '{32'hFFFF_FFFC, 3, 32'h3FFF_FFFC, 6'h3F, 22'h3FFFFF, 1, 0, 0, 32'h2222_0000};
    vecs[3] = '{32'h0000_0400, 1, 32'h0000_0100, 6'h00, 22'h00001, -1, 1, 0, 32'h3333_0000};
    vecs[4] = '{32'h0000_0048, 1, 32'h0000_0010, 6'h04, 22'h00000, -1, 0, 1, 32'h4444_0000};
    vecs[5] = '{32'h2000_0010, 2, 32'h0800_0004, 6'h01, 22'h80000, -1, 0, 0, 32'h5555_0000};
    vecs[6] = '{32'h0000_0048, 2, 32'h0000_0010, 6'h04, 22'h00000, 1, 0, 0, 32'h0000_00B0};

    nrst        = 1'b0;
    lookup_miss = 1'b0;
    miss_pc     = '0;
    flush       = 1'b0;
    word_ready  = 1'b0;
    imem_word   = '0;
    #2;
    chk("rst_i_miss", 64'(i_miss), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_fill_we", 64'(fill_we), 64'd0);
    chk("rst_tag_we", 64'(tag_we), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    chk("rst_iram_address", 64'(iram_address), 64'd0);
    chk("rst_fill_index", 64'(fill_index), 64'd0);
    chk("rst_fill_tag", 64'(fill_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;

    // Spurious word in IDLE: must not write nor advance the counter.
    word_ready = 1'b1;
    imem_word  = 32'hBAD0_0001;
    @(negedge clk);
    chk("idle_spur_fill_we", 64'(fill_we), 64'd0);
    @(posedge clk); #1;
    word_ready = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_refill(vecs[i], vecs[i].hold && (i < 6), (i < 6) ? vecs[i+1].pc : 32'h0);
    end

    // Asynchronous reset after two words: outputs drop at once and nothing installs.
    @(posedge clk); #1;
    lookup_miss = 1'b1;
    miss_pc     = 32'h0000_0048;
    @(posedge clk); #1;
    lookup_miss = 1'b0;
    for (int k = 0; k < 2; k++) begin
      word_ready = 1'b1;
      imem_word  = 32'hC0 + 32'(k);
      e.idx = 6'h04;
      e.off = 2'(k);
      e.dat = 32'hC0 + 32'(k);
      fq.push_back(e);
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    imem_word  = 32'hC2;
    chk("pre_rst_i_miss", 64'(i_miss), 64'd1);
    #1 nrst = 1'b0;
    #1;
    chk("arst_i_miss", 64'(i_miss), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_fill_we", 64'(fill_we), 64'd0);
    chk("arst_iram_address", 64'(iram_address), 64'd0);
    chk("arst_fill_index", 64'(fill_index), 64'd0);
    @(posedge clk); #1;
    word_ready = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    run_refill(vecs[0], 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    chk("fill_queue_empty", 64'(fq.size()), 64'd0);
    chk("tag_queue_empty", 64'(tq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Instruction-cache miss/refill controller inside riscv_core, directly upstream of the IRAM refill port.
- Accepts a miss from the fetch-stage lookup and raises i_miss with the line-base word address on iram_address.
- Captures the word_ready/imem_word stream into the cache data array, then writes tag/valid.
- Stalls fetch until the line is installed.

Parameters:
- PC_W, 32, width of fetch PC and of iram_address.
- WORD_W, 32, width of imem_word and of a cache data word.
- WORDS_PER_LINE, 4, words per cache line; power of two, 2..64.
- INDEX_W, 6, cache set index width.

Ports:
- clk  in  1  core clock
- nrst  in  1  asynchronous active-low reset
- lookup_miss  in  1  fetch lookup missed this cycle
- miss_pc  in  PC_W  byte PC of the missing fetch; valid with lookup_miss
- flush  in  1  pipeline flush (branch redirect)
- word_ready  in  1  one-cycle pulse: imem_word is valid
- imem_word  in  WORD_W  refill data word
- i_miss  out  1  refill request to the IRAM side
- iram_address  out  PC_W  word address of the line base
- fill_we  out  1  data-array write strobe
- fill_index  out  INDEX_W  set being filled
- fill_offset  out  log2(WORDS_PER_LINE)  word slot within the line
- fill_data  out  WORD_W  word to write
- tag_we  out  1  tag/valid write strobe
- fill_tag  out  PC_W-INDEX_W-log2(WORDS_PER_LINE)-2  tag to write
- stall  out  1  hold fetch
- fill_done  out  1  one-cycle pulse: line installed

Behaviour:
- Address split: OFF_W = log2(WORDS_PER_LINE).
  - word offset = miss_pc[OFF_W+1:2]
  - index = miss_pc[INDEX_W+OFF_W+1:OFF_W+2]
  - tag = the remaining upper bits
- iram_address = (miss_pc >> 2) with low OFF_W bits cleared, zero-extended to PC_W. Latched when the miss is accepted.
- FSM states IDLE, REFILL, INSTALL.
  - IDLE: i_miss=0, stall=0. lookup_miss & ~flush -> latch tag, index and base address; clear word counter; go to REFILL. With flush=1 the miss is ignored.
  - REFILL: i_miss=1 (registered, high from the first cycle in REFILL), stall=1.
    - Each cycle with word_ready=1: fill_we=1 combinationally, fill_data=imem_word, fill_offset=counter, fill_index=latched index; counter increments.
    - word_ready on counter = WORDS_PER_LINE-1 -> INSTALL.
    - Words arrive strictly in order from the base address, at any spacing. No timeout.
  - INSTALL (1 cycle): i_miss=0, tag_we=1, fill_tag=latched tag, fill_done=1, stall=1 -> IDLE.
- i_miss is low for at least one cycle between consecutive refills, so the IRAM side can rewind its word displacement.
- word_ready outside REFILL is ignored: no fill_we, no counter change.
- lookup_miss during REFILL/INSTALL is ignored; fetch re-looks-up after stall drops.
- flush during REFILL does not abort. The line completes and installs, keeping cache and IRAM side consistent.
- Reset (asynchronous, any state, including mid-refill) -> IDLE.
  - i_miss, fill_we, tag_we, stall and fill_done go to 0 immediately.
  - iram_address, fill_index, fill_tag and counter go to 0.
  - A partially filled line is left invalid: no tag write.
- Latency for N-cycle word spacing: miss accepted at cycle 0; INSTALL at cycle 1+N*WORDS_PER_LINE; stall drops the following cycle.

Optional Feature:
- Macro ICACHE_EARLY_RESTART_EN.
- Defined:
  - Adds outputs early_valid (1) and early_word (WORD_W).
  - Latches the critical word offset of miss_pc.
  - When that word arrives with word_ready in REFILL: early_valid=1 for that cycle, early_word=imem_word, and stall is released from the next cycle. The FSM still completes the refill.
  - Suppressed (early_valid held 0, stall held to INSTALL) if flush was seen at any point since the miss was accepted.
  - A new lookup_miss before IDLE is still ignored.
- Undefined: ports absent; stall behaves as above.

Test Plan:
- Reset, then lookup_miss with miss_pc=0x0000_0048; 4 word_ready pulses every 2 cycles with data 0xA0..0xA3.
  - Required: iram_address=0x10, fill_index=0x04.
  - fill_offset 0,1,2,3 with matching data.
  - tag_we and fill_done in the cycle after the 4th word; fill_tag=0.
  - i_miss low in that same cycle.
- Back-to-back misses (second lookup_miss held during the first refill) -> second is ignored; i_miss is low ≥1 cycle, then a new refill with the new base address.
- flush pulsed mid-refill -> all 4 words are still written, tag_we still fires, i_miss stays high until INSTALL.
- nrst dropped after 2 words -> i_miss, stall and fill_we are 0 asynchronously; no tag_we. After release, a new miss restarts at offset 0.
- Spurious word_ready in IDLE and in INSTALL -> no fill_we, and the counter is unchanged on the next refill.
- With ICACHE_EARLY_RESTART_EN, miss_pc=0x0000_0048 (critical offset 2):
  - early_valid pulses together with the 3rd word, and stall falls the next cycle.
  - Repeat with flush before the 3rd word -> no early_valid.
